rf_sb: RTL and testbench
========================

# rf_sb

Parametrised multi-port register file with an integrated scoreboard for the pipelined RV32I core. It generalises the single-write, dual-read file to NRD asynchronous read ports and NWR synchronous write ports, and adds optional same-cycle bypass. It also keeps per-register pending bits so decode can detect RAW hazards against in-flight producers. It sits between decode (read, allocate) and writeback (write, release).

## Interface

- XLEN, 32: data width.
- NREGS, 32: register count (power of two, ≥2); AW = clog2(NREGS).
- NRD, 2: read ports.
- NWR, 2: write ports; higher index has priority.
- BYPASS_EN, 0: 1 = same-cycle write data visible on read ports.

- i_clk  in  1  global clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_raddr  in  NRD*AW  read addresses; port k at [k*AW +: AW].
- o_rdata  out  NRD*XLEN  read data, combinational.
- o_rbusy  out  NRD  read register pending (hazard), combinational.
- i_wen  in  NWR  write enables.
- i_waddr  in  NWR*AW  write addresses.
- i_wdata  in  NWR*XLEN  write data.
- i_alloc_en  in  1  mark i_alloc_addr pending (instruction issued with rd).
- i_alloc_addr  in  AW  destination being allocated.
- i_flush  in  1  clear all pending bits.
- o_busy_vec  out  NREGS  registered pending bits; bit 0 always 0.

## Operation

- Register 0 is hardwired zero: reads return 0, o_rbusy = 0, writes and allocations to it are ignored.
- Write: on the clock edge, every enabled port with a nonzero address writes. If several ports target the same address, the highest-index port's data is stored.
- Read port k, address a≠0:
  - If BYPASS_EN and some enabled write port matches a, the output is the wdata of the highest-index matching port.
  - Otherwise the output is the stored value.
- Pending update per register r≠0 each edge, in priority order (first match wins): i_rst → 0; i_flush → 0; alloc to r → 1; any enabled write to r → 0; otherwise hold.
  - Alloc and write to the same r in one cycle leaves r pending, because the new producer supersedes.
  - Writes commit data during i_flush; only pending bits are cleared.
- o_rbusy[k] = pending[a] && !(BYPASS_EN && write match on a). Allocation does not affect o_rbusy in the same cycle.
- A write to a non-pending register is legal: data updates and pending stays 0.

## Timing

- Reads have zero latency, combinational from state and, when BYPASS_EN, from write inputs.
- Writes and pending updates become visible the cycle after the edge.
- Reset: on the first edge with i_rst=1, all registers become 0 and all pending bits become 0. From the next cycle o_rdata = 0, o_rbusy = 0 and o_busy_vec = 0. Writes, allocations and flushes are ignored while i_rst=1.
- Reset mid-operation discards all pending state and data, with no partial writes.
- With BYPASS_EN=0, a read in the same cycle as a write returns the old value.

## Structure

- Shared header rf_defs.vh holds the default XLEN/NREGS/NRD/NWR values and a clog2 function macro, and is used by rf_sb and the core.
- Sub-module rf_scoreboard (params NREGS, NWR) holds the pending-bit array, alloc/release/flush priority and o_busy_vec.
- rf_sb holds the data array, write-priority mux and read/bypass muxes, and instantiates rf_scoreboard.
- Register and pending reset uses a generate/for over registers, not hand-unrolled assignments.

## Test plan

- Reset, then read all 32 addresses on both ports → all 0, o_busy_vec = 0.
- BYPASS_EN=0: write x5 = 0xDEADBEEF on port 0 and read x5 the same cycle → old value 0; next cycle → 0xDEADBEEF. With BYPASS_EN=1, the same-cycle read → 0xDEADBEEF and o_rbusy = 0.
- Ports 0 and 1 both write x7 (0x11111111 and 0x22222222) → x7 = 0x22222222. A write of 0x1234 to x0 → x0 still reads 0.
- Alloc x3 → next cycle o_busy_vec[3] = 1 and a read of x3 gives o_rbusy = 1. Write x3 = 0x42 → next cycle busy = 0 and data = 0x42. Alloc x3 and write x3 together → busy stays 1 and data = the new value.
- Alloc x4, x9 and x31 in successive cycles, then assert i_flush together with a write x9 = 0xA5 and alloc x10 → o_busy_vec = 0 and x9 = 0xA5.
- Assert i_rst mid-stream with x6 pending and holding 0x99, plus a concurrent write x6 = 0x77 → next cycle x6 = 0 and busy = 0.

Source files
------------

// File: rtl/rf_sb_pkg.sv
// rf_sb_pkg
//   Shared defaults and helpers for the rf_sb register file and its
//   scoreboard. The core imports the same values, so the data width and
//   register count stay consistent across the pipeline.
//   No ports (package).
package rf_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;

    // Address width for a file of n registers. The result is at least 1 so
    // that degenerate sizes still produce a legal vector.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
//   Per-register pending bits used by decode to detect RAW hazards against
//   in-flight producers. Bit 0 is never pending.
//   Update priority per register r != 0 on each edge:
//     reset -> 0, flush -> 0, alloc to r -> 1, write to r -> 0, else hold.
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_wen        NWR write enables (release)
//   i_waddr      NWR*AW write addresses
//   i_alloc_en   mark i_alloc_addr pending
//   i_alloc_addr destination being allocated
//   i_flush      clear all pending bits
//   o_busy_vec   registered pending bits, bit 0 tied to 0
module rf_scoreboard
    import rf_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = NWR_DEF,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NWR-1:0]    i_wen,
    input  logic [NWR*AW-1:0] i_waddr,
    input  logic              i_alloc_en,
    input  logic [AW-1:0]     i_alloc_addr,
    input  logic              i_flush,
    output logic [NREGS-1:0]  o_busy_vec
);

    assign o_busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_pend
        logic wr_hit;
        logic pend;

        // NOTE: every variable written in always_comb gets a default first,
        // otherwise paths that skip the assignment infer a latch.
        always_comb begin
            wr_hit = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (i_wen[w] && i_waddr[w*AW +: AW] == AW'(r)) begin
                    wr_hit = 1'b1;
                end
            end
        end

        // NOTE: state is updated with non-blocking assignments so that all
        // flops sample pre-edge values regardless of process ordering.
        // Allocation outranks release: a new producer supersedes the one
        // that is writing back in the same cycle.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                pend <= 1'b0;
            end else if (i_flush) begin
                pend <= 1'b0;
            end else if (i_alloc_en && i_alloc_addr == AW'(r)) begin
                pend <= 1'b1;
            end else if (wr_hit) begin
                pend <= 1'b0;
            end
        end

        assign o_busy_vec[r] = pend;
    end

endmodule

// File: rtl/rf_sb.sv
// rf_sb
//   Multi-port register file with integrated scoreboard for the pipelined
//   RV32I core. NRD combinational read ports, NWR synchronous write ports
//   (higher index wins on address collision), optional same-cycle bypass of
//   write data to the read ports. Register 0 reads as zero and ignores
//   writes and allocations.
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset (clears data and pending)
//   i_raddr      NRD*AW read addresses, port k at [k*AW +: AW]
//   o_rdata      NRD*XLEN read data, combinational
//   o_rbusy      NRD read-register-pending flags, combinational
//   i_wen        NWR write enables
//   i_waddr      NWR*AW write addresses
//   i_wdata      NWR*XLEN write data
//   i_alloc_en   mark i_alloc_addr pending
//   i_alloc_addr destination being allocated
//   i_flush      clear all pending bits (data writes still commit)
//   o_busy_vec   registered pending bits, bit 0 always 0
module rf_sb
    import rf_sb_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREGS     = NREGS_DEF,
    parameter int NRD       = NRD_DEF,
    parameter int NWR       = NWR_DEF,
    parameter bit BYPASS_EN = 1'b0,
    parameter int AW        = addr_width(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NRD*AW-1:0]   i_raddr,
    output logic [NRD*XLEN-1:0] o_rdata,
    output logic [NRD-1:0]      o_rbusy,
    input  logic [NWR-1:0]      i_wen,
    input  logic [NWR*AW-1:0]   i_waddr,
    input  logic [NWR*XLEN-1:0] i_wdata,
    input  logic                i_alloc_en,
    input  logic [AW-1:0]       i_alloc_addr,
    input  logic                i_flush,
    output logic [NREGS-1:0]    o_busy_vec
);

    logic [XLEN-1:0] rf_q [NREGS];

    assign rf_q[0] = '0;

    // Storage: one flop row per architectural register, each with its own
    // write-priority mux. Walking the ports in ascending order lets the
    // highest-index matching port win.
    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        logic            hit;
        logic [XLEN-1:0] val;
        logic [XLEN-1:0] q;

        always_comb begin
            hit = 1'b0;
            val = '0;
            for (int w = 0; w < NWR; w++) begin
                if (i_wen[w] && i_waddr[w*AW +: AW] == AW'(r)) begin
                    hit = 1'b1;
                    val = i_wdata[w*XLEN +: XLEN];
                end
            end
        end

        // NOTE: the data array is reset entry by entry because a reset must
        // leave every architectural register reading zero; this keeps it in
        // flops rather than a RAM macro.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                q <= '0;
            end else if (hit) begin
                q <= val;
            end
        end

        assign rf_q[r] = q;
    end

    // Read ports. The bypass search also picks the highest-index match, so
    // it agrees with what the array will hold after the edge.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] data;
        logic            byp;

        always_comb begin
            ra   = i_raddr[k*AW +: AW];
            data = rf_q[ra];
            byp  = 1'b0;
            if (BYPASS_EN) begin
                for (int w = 0; w < NWR; w++) begin
                    if (i_wen[w] && i_waddr[w*AW +: AW] == ra) begin
                        byp  = 1'b1;
                        data = i_wdata[w*XLEN +: XLEN];
                    end
                end
            end
            if (ra == '0) begin
                data = '0;
                byp  = 1'b0;
            end
        end

        assign o_rdata[k*XLEN +: XLEN] = data;
        // A producer writing back this cycle resolves the hazard only when
        // its data is forwarded; allocation shows up a cycle later.
        assign o_rbusy[k] = o_busy_vec[ra] && !byp;
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wen        (i_wen),
        .i_waddr      (i_waddr),
        .i_alloc_en   (i_alloc_en),
        .i_alloc_addr (i_alloc_addr),
        .i_flush      (i_flush),
        .o_busy_vec   (o_busy_vec)
    );

endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb
//   Directed bench for rf_sb. Two instances share all inputs: one without
//   bypass (dut 0) and one with bypass (dut 1). The stimulus process pushes
//   hand-computed expectations into a queue each cycle; a monitor on the
//   falling edge pops and compares them against the live outputs.
module tb_rf_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  localparam int K_RDATA = 0;
  localparam int K_RBUSY = 1;
  localparam int K_BVEC  = 2;

  typedef struct {
    string       name;
    int          dut;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   raddr;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;

  logic [NRD*XLEN-1:0] rdata_nb, rdata_byp;
  logic [NRD-1:0]      rbusy_nb, rbusy_byp;
  logic [NREGS-1:0]    bvec_nb, bvec_byp;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rf_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS_EN(1'b0)) u_nb (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_nb), .o_rbusy(rbusy_nb),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_alloc_en(alloc_en),
    .i_alloc_addr(alloc_addr), .i_flush(flush), .o_busy_vec(bvec_nb)
  );

  rf_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS_EN(1'b1)) u_byp (
    .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_byp), .o_rbusy(rbusy_byp),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_alloc_en(alloc_en),
    .i_alloc_addr(alloc_addr), .i_flush(flush), .o_busy_vec(bvec_byp)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares everything queued for the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_RDATA: act = (e.dut == 0) ? rdata_nb[e.port*XLEN +: XLEN]
                                    : rdata_byp[e.port*XLEN +: XLEN];
        K_RBUSY: act = {31'b0, (e.dut == 0) ? rbusy_nb[e.port] : rbusy_byp[e.port]};
        default: act = (e.dut == 0) ? bvec_nb : bvec_byp;
      endcase
      check($sformatf("%s (dut %0d port %0d)", e.name, e.dut, e.port), act, e.exp);
    end
  end

  task automatic push(input string nm, input int dut, input int kind, input int port,
                      input logic [31:0] v);
    exp_t e;
    e.name = nm; e.dut = dut; e.kind = kind; e.port = port; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    rst = 1'b0; wen = '0; waddr = '0; wdata = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int port, input int a);
    raddr[port*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int port, input int a, input logic [31:0] d);
    wen[port] = 1'b1;
    waddr[port*AW +: AW] = AW'(a);
    wdata[port*XLEN +: XLEN] = d;
  endtask

  task automatic alloc(input int a);
    alloc_en = 1'b1;
    alloc_addr = AW'(a);
  endtask

  // Advance one cycle; inputs change 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    raddr = '0;
    rst = 1'b1;
    step();
    idle();

    check("reset_bvec_direct_nb", bvec_nb, 32'h0);
    check("reset_bvec_direct_byp", bvec_byp, 32'h0);

    // Reset: every address on both ports reads zero, nothing pending.
    for (int a = 0; a < NREGS; a++) begin
      set_rd(0, a);
      set_rd(1, NREGS - 1 - a);
      for (int d = 0; d < 2; d++) begin
        push("reset_rd0", d, K_RDATA, 0, 32'h0);
        push("reset_rd1", d, K_RDATA, 1, 32'h0);
        push("reset_rbusy0", d, K_RBUSY, 0, 32'h0);
      end
      push("reset_bvec", 0, K_BVEC, 0, 32'h0);
      step();
    end

    // Same-cycle write/read of x5: old value without bypass, new with.
    set_wr(0, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    push("wr_x5_same_nb", 0, K_RDATA, 0, 32'h0);
    push("wr_x5_same_byp", 1, K_RDATA, 0, 32'hDEADBEEF);
    push("wr_x5_same_rbusy", 1, K_RBUSY, 0, 32'h0);
    step();
    idle();
    for (int d = 0; d < 2; d++) begin
      push("wr_x5_next", d, K_RDATA, 0, 32'hDEADBEEF);
      push("wr_nonpend_bvec", d, K_BVEC, 0, 32'h0);
    end
    step();

    // Both ports write x7: port 1 wins, in the array and on the bypass.
    set_wr(0, 7, 32'h11111111);
    set_wr(1, 7, 32'h22222222);
    set_rd(0, 7);
    push("dual_wr_same_nb", 0, K_RDATA, 0, 32'h0);
    push("dual_wr_same_byp", 1, K_RDATA, 0, 32'h22222222);
    step();
    idle();
    set_rd(1, 7);
    for (int d = 0; d < 2; d++) begin
      push("dual_wr_x7_p0", d, K_RDATA, 0, 32'h22222222);
      push("dual_wr_x7_p1", d, K_RDATA, 1, 32'h22222222);
    end
    step();

    // Write to x0 is ignored, including the bypass path.
    set_wr(0, 0, 32'h00001234);
    set_rd(0, 0);
    push("wr_x0_same_byp", 1, K_RDATA, 0, 32'h0);
    step();
    idle();
    for (int d = 0; d < 2; d++) push("wr_x0_next", d, K_RDATA, 0, 32'h0);
    step();

    // Alloc x3: not visible on o_rbusy until the next cycle.
    alloc(3);
    set_rd(0, 3);
    for (int d = 0; d < 2; d++) push("alloc_x3_same_rbusy", d, K_RBUSY, 0, 32'h0);
    step();
    idle();
    for (int d = 0; d < 2; d++) begin
      push("alloc_x3_bvec", d, K_BVEC, 0, 32'h0000_0008);
      push("alloc_x3_rbusy", d, K_RBUSY, 0, 32'h1);
    end
    step();

    // Writeback x3 = 0x42: bypass clears the hazard in the same cycle.
    set_wr(1, 3, 32'h42);
    push("rel_x3_same_rbusy_nb", 0, K_RBUSY, 0, 32'h1);
    push("rel_x3_same_rbusy_byp", 1, K_RBUSY, 0, 32'h0);
    push("rel_x3_same_rd_byp", 1, K_RDATA, 0, 32'h42);
    push("rel_x3_same_rd_nb", 0, K_RDATA, 0, 32'h0);
    step();
    idle();
    for (int d = 0; d < 2; d++) begin
      push("rel_x3_bvec", d, K_BVEC, 0, 32'h0);
      push("rel_x3_rd", d, K_RDATA, 0, 32'h42);
      push("rel_x3_rbusy", d, K_RBUSY, 0, 32'h0);
    end
    step();

    // Alloc and write x3 together: stays pending, data updates.
    alloc(3);
    set_wr(0, 3, 32'h55);
    step();
    idle();
    for (int d = 0; d < 2; d++) begin
      push("alloc_wr_x3_bvec", d, K_BVEC, 0, 32'h0000_0008);
      push("alloc_wr_x3_rd", d, K_RDATA, 0, 32'h55);
      push("alloc_wr_x3_rbusy", d, K_RBUSY, 0, 32'h1);
    end
    step();

    // Allocate x4, x9, x31 in successive cycles, then flush.
    alloc(4);  step();
    alloc(9);  step();
    alloc(31); step();
    idle();
    for (int d = 0; d < 2; d++)
      push("multi_alloc_bvec", d, K_BVEC, 0, 32'h8000_0218);
    step();
    flush = 1'b1;
    set_wr(0, 9, 32'hA5);
    alloc(10);
    step();
    idle();
    set_rd(0, 9);
    set_rd(1, 10);
    for (int d = 0; d < 2; d++) begin
      push("flush_bvec", d, K_BVEC, 0, 32'h0);
      push("flush_x9_rd", d, K_RDATA, 0, 32'hA5);
      push("flush_x10_rbusy", d, K_RBUSY, 1, 32'h0);
    end
    step();

    // x6 pending holding 0x99, then reset with a concurrent write.
    alloc(6);
    set_wr(0, 6, 32'h99);
    step();
    idle();
    set_rd(0, 6);
    for (int d = 0; d < 2; d++) begin
      push("pre_rst_bvec", d, K_BVEC, 0, 32'h0000_0040);
      push("pre_rst_x6_rd", d, K_RDATA, 0, 32'h99);
    end
    step();
    rst = 1'b1;
    set_wr(0, 6, 32'h77);
    step();
    idle();
    set_rd(0, 6);
    set_rd(1, 5);
    for (int d = 0; d < 2; d++) begin
      push("mid_rst_x6_rd", d, K_RDATA, 0, 32'h0);
      push("mid_rst_x6_rbusy", d, K_RBUSY, 0, 32'h0);
      push("mid_rst_bvec", d, K_BVEC, 0, 32'h0);
      push("mid_rst_x5_rd", d, K_RDATA, 1, 32'h0);
    end
    step();
    step();

    check("queue_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
